// File: rtl/port_responder_pkg.sv
// Shared constants and types for the port_responder command channel and its FIFO.
package port_responder_pkg;

    localparam int unsigned DATA_W = 8;

    localparam logic [1:0] OP_CLR  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_PEEK = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StAck  = 2'b10
    } state_e;

    localparam int unsigned ST_ACK   = 7;
    localparam int unsigned ST_FULL  = 6;
    localparam int unsigned ST_EMPTY = 5;
    localparam int unsigned ST_ERR   = 4;

endpackage

// File: rtl/port_fifo.sv
// Small byte FIFO with wrapping pointers and a separate count so full/empty are unambiguous.
module port_fifo
    import port_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_head,
    output logic              o_full,
    output logic              o_empty,
    output logic [AW:0]       o_count
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rptr];
    assign w_push_ok = i_push && !o_full && !i_flush;
    assign w_pop_ok  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
            if (w_push_ok && !w_pop_ok)      r_count <= r_count + 1'b1;
            else if (w_pop_ok && !w_push_ok) r_count <= r_count - 1'b1;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/port_responder.sv
// Toggle-handshake command responder on the CPU's I/O ports, fronting a small byte FIFO.
module port_responder
    import port_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] Outport0,
    input  logic [7:0] Outport1,
    output logic [7:0] Inport0,
    output logic [7:0] Inport1
);

    state_e            r_state;
    state_e            w_next;
    logic              r_req;
    logic [1:0]        r_op;
    logic [DATA_W-1:0] r_wdata;
    logic              r_ack;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;

    logic              w_req_edge;
    logic              w_capture;
    logic              w_exec;
    logic              w_do_ack;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic [DATA_W-1:0] w_head;
    logic              w_full;
    logic              w_empty;
    logic [AW:0]       w_count;
    logic              w_unused_cmd;

    assign w_req_edge   = (Outport0[7] != r_req);
    assign w_unused_cmd = ^Outport0[6:2];

    port_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_wdata (r_wdata),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= StIdle;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            StIdle:  if (w_req_edge) w_next = StExec;
            StExec:  w_next = StAck;
            StAck:   w_next = StIdle;
            default: w_next = StIdle;
        endcase
    end

    always_comb begin
        w_capture = 1'b0;
        w_exec    = 1'b0;
        w_do_ack  = 1'b0;
        unique case (r_state)
            StIdle:  w_capture = w_req_edge;
            StExec:  w_exec    = 1'b1;
            StAck:   w_do_ack  = 1'b1;
            default: ;
        endcase
    end

    assign w_push  = w_exec && (r_op == OP_PUSH);
    assign w_pop   = w_exec && (r_op == OP_POP);
    assign w_flush = w_exec && (r_op == OP_CLR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req   <= 1'b0;
            r_op    <= OP_CLR;
            r_wdata <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_capture) begin
                r_req   <= Outport0[7];
                r_op    <= Outport0[1:0];
                r_wdata <= Outport1;
            end
            if (w_exec) begin
                unique case (r_op)
                    OP_CLR:  r_err <= 1'b0;
                    OP_PUSH: if (w_full) r_err <= 1'b1;
                    OP_POP, OP_PEEK: begin
                        if (w_empty) r_err   <= 1'b1;
                        else         r_rdata <= w_head;
                    end
                    default: ;
                endcase
            end
            if (w_do_ack) r_ack <= r_req;
        end
    end

    always_comb begin
        Inport0           = {4'b0000, 4'(w_count)};
        Inport0[ST_ACK]   = r_ack;
        Inport0[ST_FULL]  = w_full;
        Inport0[ST_EMPTY] = w_empty;
        Inport0[ST_ERR]   = r_err;
    end

    assign Inport1 = r_rdata;

endmodule
